// File: rtl/hlsm_pkg.sv
// Shared types and helpers for the iterating differential-equation FSMD.
package hlsm_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE_A = 3'd1,
      S_ISSUE_B = 3'd2,
      S_WAIT_A  = 3'd3,
      S_ISSUE_C = 3'd4,
      S_WAIT_C  = 3'd5,
      S_UPDATE  = 3'd6,
      S_DONE    = 3'd7
   } state_t;

   // Identifies which product of a step is travelling through the multiplier.
   typedef enum logic [1:0] {
      TAG_A = 2'd0,
      TAG_B = 2'd1,
      TAG_C = 2'd2
   } tag_t;

   localparam logic [1:0] THREE = 2'd3;

   function automatic int unsigned itw(input int unsigned max_iter);
      return $clog2(max_iter + 1);
   endfunction

   // Constant multiply by THREE as a shift-add sum; callers truncate to their width.
   function automatic logic [63:0] times_three(input logic [63:0] v);
      logic [63:0] acc;
      acc = '0;
      for (int i = 0; i < 2; i++)
         if (THREE[i]) acc = acc + (v << i);
      return acc;
   endfunction

endpackage

// File: rtl/hlsm_diffeq_iter_if.sv
// Host-side start/done bus of the differential-equation accelerator.
interface hlsm_diffeq_iter_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ITW   = 8
);
   logic                    Start;
   logic signed [WIDTH-1:0] u, x, y, dx, a;
   logic                    Done;
   logic signed [WIDTH-1:0] u1, x1, y1;
   logic                    c;
   logic [ITW-1:0]          iter;

   modport master (output Start, u, x, y, dx, a, input  Done, u1, x1, y1, c, iter);
   modport slave  (input  Start, u, x, y, dx, a, output Done, u1, x1, y1, c, iter);
endinterface

// File: rtl/hlsm_mul_pipe.sv
// Shared pipelined signed multiplier with valid/tag tracking alongside the data.
module hlsm_mul_pipe
   import hlsm_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned MUL_LAT = 2
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic signed [WIDTH-1:0] op_a,
   input  logic signed [WIDTH-1:0] op_b,
   input  logic                    vld_in,
   input  tag_t                    tag_in,
   output logic signed [WIDTH-1:0] prod,
   output logic                    prod_vld,
   output tag_t                    prod_tag,
   output logic                    nxt_vld,
   output tag_t                    nxt_tag
);
   logic signed [WIDTH-1:0] prod_q [MUL_LAT];
   logic                    vld_q  [MUL_LAT];
   tag_t                    tag_q  [MUL_LAT];

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         for (int unsigned i = 0; i < MUL_LAT; i++) begin
            prod_q[i] <= '0;
            vld_q[i]  <= 1'b0;
            tag_q[i]  <= TAG_A;
         end
      end else begin
         prod_q[0] <= WIDTH'(op_a * op_b);
         vld_q[0]  <= vld_in;
         tag_q[0]  <= tag_in;
         for (int unsigned i = 1; i < MUL_LAT; i++) begin
            prod_q[i] <= prod_q[i-1];
            vld_q[i]  <= vld_q[i-1];
            tag_q[i]  <= tag_q[i-1];
         end
      end
   end

   assign prod     = prod_q[MUL_LAT-1];
   assign prod_vld = vld_q[MUL_LAT-1];
   assign prod_tag = tag_q[MUL_LAT-1];

   // Product that becomes valid next cycle; none is visible a cycle ahead with one stage.
   if (MUL_LAT > 1) begin : g_nxt
      assign nxt_vld = vld_q[MUL_LAT-2];
      assign nxt_tag = tag_q[MUL_LAT-2];
   end else begin : g_nxt_none
      assign nxt_vld = 1'b0;
      assign nxt_tag = TAG_A;
   end
endmodule

// File: rtl/hlsm_diffeq_iter.sv
// Iterating Euler-step FSMD: repeats u/x/y updates until x >= a or MAX_ITER steps.
module hlsm_diffeq_iter
   import hlsm_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned MUL_LAT  = 2,
   parameter int unsigned MAX_ITER = 255
) (
   input  logic Clk,
   input  logic Rst,
   hlsm_diffeq_iter_if.slave bus
);
   localparam int unsigned ITW = itw(MAX_ITER);
   typedef logic signed [WIDTH-1:0] word_t;

   state_t         state, state_nx;
   word_t          wu, wx, wy, wdx, wa, t2, t6;
   logic [ITW-1:0] steps, steps_nx, iter_q;
   word_t          u1_q, x1_q, y1_q;
   logic           c_q, done_q;
   word_t          mul_a, mul_b, prod;
   logic           mul_vld, prod_vld, nxt_vld;
   tag_t           mul_tag, prod_tag, nxt_tag;
   logic           capture, ld_t2, upd;
   word_t          u_nx, x_nx, y_nx;
   logic           c_nx, last_c, a_ready, c_next;

   hlsm_mul_pipe #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) u_mul (
      .Clk(Clk), .Rst(Rst),
      .op_a(mul_a), .op_b(mul_b), .vld_in(mul_vld), .tag_in(mul_tag),
      .prod(prod), .prod_vld(prod_vld), .prod_tag(prod_tag),
      .nxt_vld(nxt_vld), .nxt_tag(nxt_tag)
   );

   // Step results; in UPDATE the multiplier output is t3.
   assign u_nx     = wu - prod - t6;
   assign x_nx     = wx + wdx;
   assign y_nx     = wy + t2;
   assign c_nx     = (x_nx < wa);
   assign steps_nx = steps + ITW'(1);
   assign last_c   = !c_nx || (steps_nx == ITW'(MAX_ITER));
   assign a_ready  = prod_vld && (prod_tag == TAG_A);
   assign c_next   = nxt_vld && (nxt_tag == TAG_C);

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      mul_a    = '0;
      mul_b    = '0;
      mul_vld  = 1'b0;
      mul_tag  = TAG_A;
      capture  = 1'b0;
      ld_t2    = 1'b0;
      upd      = 1'b0;
      case (state)
         S_IDLE: if (bus.Start) begin
            capture  = 1'b1;
            state_nx = S_ISSUE_A;
         end
         S_ISSUE_A: begin
            mul_a    = wu;
            mul_b    = wdx;
            mul_vld  = 1'b1;
            mul_tag  = TAG_A;
            state_nx = S_ISSUE_B;
         end
         S_ISSUE_B: begin
            mul_a    = WIDTH'(times_three(64'(wy)));
            mul_b    = wdx;
            mul_vld  = 1'b1;
            mul_tag  = TAG_B;
            ld_t2    = a_ready;
            state_nx = a_ready ? S_ISSUE_C : S_WAIT_A;
         end
         S_WAIT_A: if (a_ready) begin
            ld_t2    = 1'b1;
            state_nx = S_ISSUE_C;
         end
         S_ISSUE_C: begin
            mul_a    = WIDTH'(times_three(64'(wx)));
            mul_b    = t2;
            mul_vld  = 1'b1;
            mul_tag  = TAG_C;
            state_nx = (MUL_LAT == 1) ? S_UPDATE : S_WAIT_C;
         end
         S_WAIT_C: if (c_next) state_nx = S_UPDATE;
         S_UPDATE: begin
            upd      = 1'b1;
            state_nx = last_c ? S_DONE : S_ISSUE_A;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Working registers, product latches and result registers.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         {wu, wx, wy, wdx, wa, t2, t6} <= '0;
         steps  <= '0;
         u1_q   <= '0;
         x1_q   <= '0;
         y1_q   <= '0;
         c_q    <= 1'b0;
         iter_q <= '0;
         done_q <= 1'b0;
      end else begin
         if (capture) begin
            wu    <= bus.u;
            wx    <= bus.x;
            wy    <= bus.y;
            wdx   <= bus.dx;
            wa    <= bus.a;
            steps <= '0;
         end
         if (ld_t2) t2 <= prod;
         if (prod_vld && (prod_tag == TAG_B)) t6 <= prod;
         if (upd) begin
            wu    <= u_nx;
            wx    <= x_nx;
            wy    <= y_nx;
            steps <= steps_nx;
         end
         if (upd && last_c) begin
            u1_q   <= u_nx;
            x1_q   <= x_nx;
            y1_q   <= y_nx;
            c_q    <= c_nx;
            iter_q <= steps_nx;
         end
         done_q <= upd && last_c;
      end
   end

   assign bus.Done = done_q;
   assign bus.u1   = u1_q;
   assign bus.x1   = x1_q;
   assign bus.y1   = y1_q;
   assign bus.c    = c_q;
   assign bus.iter = iter_q;
endmodule

// File: tb/tb_hlsm_diffeq_iter.sv
// Bench: five parameter variants share one stimulus stream and are checked against a step-loop model.
module tb_hlsm_diffeq_iter;
   localparam int NI   = 5;
   localparam int LAT [NI] = '{2, 1, 4, 2, 1};
   localparam int CAP [NI] = '{255, 255, 255, 4, 255};
   localparam int WID [NI] = '{32, 32, 32, 32, 8};
   localparam int TAIL = 12;

   logic              Clk;
   logic              Rst;
   logic              start;
   logic signed [31:0] u_in, x_in, y_in, dx_in, a_in;
   int                n_chk = 0;
   int                n_pass = 0;

   logic              dv  [NI];
   logic              oc  [NI];
   logic signed [63:0] ou [NI], ox [NI], oy [NI];
   logic [63:0]       oit [NI];

   hlsm_diffeq_iter_if #(.WIDTH(32), .ITW(8)) if0 ();
   hlsm_diffeq_iter_if #(.WIDTH(32), .ITW(8)) if1 ();
   hlsm_diffeq_iter_if #(.WIDTH(32), .ITW(8)) if2 ();
   hlsm_diffeq_iter_if #(.WIDTH(32), .ITW(3)) if3 ();
   hlsm_diffeq_iter_if #(.WIDTH(8),  .ITW(8)) if4 ();

   hlsm_diffeq_iter #(.WIDTH(32), .MUL_LAT(2), .MAX_ITER(255)) dut0 (.Clk(Clk), .Rst(Rst), .bus(if0));
   hlsm_diffeq_iter #(.WIDTH(32), .MUL_LAT(1), .MAX_ITER(255)) dut1 (.Clk(Clk), .Rst(Rst), .bus(if1));
   hlsm_diffeq_iter #(.WIDTH(32), .MUL_LAT(4), .MAX_ITER(255)) dut2 (.Clk(Clk), .Rst(Rst), .bus(if2));
   hlsm_diffeq_iter #(.WIDTH(32), .MUL_LAT(2), .MAX_ITER(4))   dut3 (.Clk(Clk), .Rst(Rst), .bus(if3));
   hlsm_diffeq_iter #(.WIDTH(8),  .MUL_LAT(1), .MAX_ITER(255)) dut4 (.Clk(Clk), .Rst(Rst), .bus(if4));

   assign {if0.Start, if0.u, if0.x, if0.y, if0.dx, if0.a} = {start, u_in, x_in, y_in, dx_in, a_in};
   assign {if1.Start, if1.u, if1.x, if1.y, if1.dx, if1.a} = {start, u_in, x_in, y_in, dx_in, a_in};
   assign {if2.Start, if2.u, if2.x, if2.y, if2.dx, if2.a} = {start, u_in, x_in, y_in, dx_in, a_in};
   assign {if3.Start, if3.u, if3.x, if3.y, if3.dx, if3.a} = {start, u_in, x_in, y_in, dx_in, a_in};
   assign {if4.Start, if4.u, if4.x, if4.y, if4.dx, if4.a} =
          {start, u_in[7:0], x_in[7:0], y_in[7:0], dx_in[7:0], a_in[7:0]};

   assign dv[0] = if0.Done; assign oc[0] = if0.c; assign oit[0] = 64'(if0.iter);
   assign ou[0] = 64'(if0.u1); assign ox[0] = 64'(if0.x1); assign oy[0] = 64'(if0.y1);
   assign dv[1] = if1.Done; assign oc[1] = if1.c; assign oit[1] = 64'(if1.iter);
   assign ou[1] = 64'(if1.u1); assign ox[1] = 64'(if1.x1); assign oy[1] = 64'(if1.y1);
   assign dv[2] = if2.Done; assign oc[2] = if2.c; assign oit[2] = 64'(if2.iter);
   assign ou[2] = 64'(if2.u1); assign ox[2] = 64'(if2.x1); assign oy[2] = 64'(if2.y1);
   assign dv[3] = if3.Done; assign oc[3] = if3.c; assign oit[3] = 64'(if3.iter);
   assign ou[3] = 64'(if3.u1); assign ox[3] = 64'(if3.x1); assign oy[3] = 64'(if3.y1);
   assign dv[4] = if4.Done; assign oc[4] = if4.c; assign oit[4] = 64'(if4.iter);
   assign ou[4] = 64'(if4.u1); assign ox[4] = 64'(if4.x1); assign oy[4] = 64'(if4.y1);

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Sign-extend the low w bits of v: arithmetic modulo 2^w.
   function automatic logic signed [63:0] sx_w(input logic signed [63:0] v, input int w);
      logic signed [63:0] t;
      t = v <<< (64 - w);
      return t >>> (64 - w);
   endfunction

   // Reference: repeated Euler steps with plain wide arithmetic, wrapped to w bits.
   task automatic model(input logic signed [63:0] iu, ix, iy, idx, ia, input int w, input int cap,
                        output logic signed [63:0] ru, rx, ry, output logic rc, output int rn);
      logic signed [63:0] u, x, y, d, a, t2;
      u = sx_w(iu, w); x = sx_w(ix, w); y = sx_w(iy, w); d = sx_w(idx, w); a = sx_w(ia, w);
      rn = 0;
      do begin
         t2 = sx_w(u * d, w);
         u  = sx_w(u - 3 * x * t2 - 3 * y * d, w);
         x  = sx_w(x + d, w);
         y  = sx_w(y + t2, w);
         rn++;
         rc = (x < a);
      end while (rc && rn < cap);
      ru = u; rx = x; ry = y;
   endtask

   task automatic check_reset(input string name);
      for (int i = 0; i < NI; i++) begin
         string p;
         p = $sformatf("%s i%0d", name, i);
         chk({p, " Done"}, 64'(dv[i]), 0);
         chk({p, " u1"}, ou[i], 0);
         chk({p, " x1"}, ox[i], 0);
         chk({p, " y1"}, oy[i], 0);
         chk({p, " c"}, 64'(oc[i]), 0);
         chk({p, " iter"}, oit[i], 0);
      end
   endtask

   // One run from a negedge; hold_k = cycle Start drops, pulse_k = extra one-cycle Start pulse.
   task automatic run_vec(input string name, input int vu, vx, vy, vdx, va,
                          input int hold_k, input int pulse_k);
      logic signed [63:0] eu [NI], ex [NI], ey [NI], su [NI], sx [NI], sy [NI];
      logic               ec [NI], sc [NI];
      logic [63:0]        sit [NI];
      int                 en [NI], eat [NI], cnt [NI], at [NI];
      int                 last;
      last = 0;
      for (int i = 0; i < NI; i++) begin
         model(64'(vu), 64'(vx), 64'(vy), 64'(vdx), 64'(va), WID[i], CAP[i],
               eu[i], ex[i], ey[i], ec[i], en[i]);
         eat[i] = en[i] * (2 * LAT[i] + 2);
         if (eat[i] > last) last = eat[i];
         cnt[i] = 0; at[i] = -1;
         su[i] = 'x; sx[i] = 'x; sy[i] = 'x; sc[i] = 1'bx; sit[i] = 'x;
      end
      u_in = vu; x_in = vx; y_in = vy; dx_in = vdx; a_in = va;
      start = 1'b1;
      @(posedge Clk);
      for (int k = 0; k <= last + TAIL; k++) begin
         @(negedge Clk);
         if (k == 0) begin
            u_in = $urandom; x_in = $urandom; y_in = $urandom; dx_in = $urandom; a_in = $urandom;
         end
         if (k == hold_k) start = 1'b0;
         if (k == pulse_k) start = 1'b1;
         if (k == pulse_k + 1) start = 1'b0;
         for (int i = 0; i < NI; i++) begin
            if (dv[i] === 1'b1 && k <= eat[i] + ((hold_k > 0) ? 0 : TAIL)) begin
               cnt[i]++;
               if (at[i] < 0) begin
                  at[i] = k; su[i] = ou[i]; sx[i] = ox[i]; sy[i] = oy[i]; sc[i] = oc[i]; sit[i] = oit[i];
               end
            end
         end
      end
      for (int i = 0; i < NI; i++) begin
         string p;
         p = $sformatf("%s i%0d", name, i);
         chk({p, " pulses"}, 64'(cnt[i]), 1);
         chk({p, " done_cycle"}, 64'(at[i]), 64'(eat[i]));
         chk({p, " u1"}, su[i], eu[i]);
         chk({p, " x1"}, sx[i], ex[i]);
         chk({p, " y1"}, sy[i], ey[i]);
         chk({p, " c"}, 64'(sc[i]), 64'(ec[i]));
         chk({p, " iter"}, sit[i], 64'(en[i]));
      end
   endtask

   initial begin
      int quiet [NI];
      Rst = 1'b0; start = 1'b0;
      u_in = '0; x_in = '0; y_in = '0; dx_in = '0; a_in = '0;
      repeat (3) @(negedge Clk);
      check_reset("por");
      Rst = 1'b1;
      @(negedge Clk);

      run_vec("single", 1, 0, 0, 1, 1, 0, -1);
      run_vec("multi", 2, 0, 0, 1, 3, 0, -1);
      run_vec("inter1", 2, 0, 0, 1, 1, 0, -1);
      run_vec("inter2", 2, 0, 0, 1, 2, 0, -1);
      run_vec("cap", 0, 0, 0, 1, 100, 0, -1);
      run_vec("wrap", 0, 127, 0, 1, -128, 0, -1);
      run_vec("bigcap", 0, 0, 0, 1, 1000, 0, -1);
      run_vec("pulse", 2, 0, 0, 1, 3, 0, 3);
      run_vec("hold", 2, 0, 0, 1, 3, 18, -1);

      // Clear the variants that restarted while Start was held.
      Rst = 1'b0;
      @(negedge Clk);
      check_reset("rst_idle");
      Rst = 1'b1;
      @(negedge Clk);

      run_vec("pre_rst", 2, 0, 0, 1, 3, 0, -1);
      u_in = 2; x_in = 0; y_in = 0; dx_in = 1; a_in = 3;
      start = 1'b1;
      @(posedge Clk);
      for (int k = 0; k <= 4; k++) begin
         @(negedge Clk);
         if (k == 0) start = 1'b0;
      end
      Rst = 1'b0;
      #1;
      check_reset("rst_wait_c");
      @(negedge Clk);
      Rst = 1'b1;
      for (int i = 0; i < NI; i++) quiet[i] = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge Clk);
         for (int i = 0; i < NI; i++) if (dv[i] === 1'b1) quiet[i]++;
      end
      for (int i = 0; i < NI; i++) chk($sformatf("post_rst i%0d done_pulses", i), 64'(quiet[i]), 0);
      run_vec("after_rst", 1, 0, 0, 1, 1, 0, -1);

      for (int r = 0; r < 12; r++) begin
         int vu, vx, vy, vdx, va;
         vu  = int'($urandom);
         vx  = int'($urandom_range(200)) - 100;
         vy  = int'($urandom);
         vdx = int'($urandom_range(20, 1));
         va  = vx + int'($urandom_range(80));
         run_vec($sformatf("rand%0d", r), vu, vx, vy, vdx, va, 0, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/hlsm_diffeq_iter.md
# hlsm_diffeq_iter

Iterating, parametrised successor to the single-step differential-equation FSMD. One Start performs repeated Euler steps (u, x, y updated per step) until x ≥ a or an iteration cap is reached. All products go through one shared pipelined multiplier. Sits in the HLS datapath library as a start/done accelerator driven by a host FSM.

## Interface
- WIDTH, 32, signed datapath width for all operands, temporaries and results
- MUL_LAT, 2, register stages in the shared multiplier (≥1)
- MAX_ITER, 255, iteration cap (≥1); ITW = $clog2(MAX_ITER+1)
- Clk  input  1  clock, all state on rising edge
- Rst  input  1  asynchronous, active-low reset
- Start  input  1  begin run; sampled only in IDLE
- u, x, y, dx, a  input  WIDTH signed  initial values / step / bound
- Done  output  1  one-cycle pulse when the result is valid
- u1, x1, y1  output  WIDTH signed  final state after the last step
- c  output  1  final x1 < a (1 = cap hit before convergence)
- iter  output  ITW  number of steps performed

## Operation
- Per step, all modulo 2^WIDTH, signed: t2=u·dx; t1=3x; t5=3y (shift-add, no multiplier); t3=t1·t2; t6=t5·dx; u'=u−t3−t6; x'=x+dx; y'=y+t2; c'=(x'<a), signed compare.
- At least one step always. Continue while c'=1 and steps<MAX_ITER.
- Start in IDLE captures u, x, y, dx, a into working registers, clears the step count and enters ISSUE_A. Start outside IDLE is ignored. Inputs may change after capture.
- States:
  - IDLE
  - ISSUE_A: multiply u·dx.
  - ISSUE_B: multiply t5·dx.
  - WAIT_A: latches t2 when it is valid.
  - ISSUE_C: multiply t1·t2.
  - WAIT_C
  - UPDATE: writes u, x, y, step count. Goes to ISSUE_A, or to DONE when the run terminates.
  - DONE: goes to IDLE.
- Output regs u1, x1, y1, c, iter load only on the terminating UPDATE edge. They hold until the next run terminates.
- Reset values: Done=0, u1=x1=y1=0, c=0, iter=0, state=IDLE.

## Timing
- Multiplier: operands issued in cycle k give a product valid in cycle k+MUL_LAT.
- Step cycles, counted from ISSUE_A = cycle 0:
  - ISSUE_A = 0, ISSUE_B = 1.
  - t2 is latched at the end of cycle MUL_LAT.
  - ISSUE_C = MUL_LAT+1.
  - UPDATE = 2·MUL_LAT+1, which also latches t3.
  - t6 (valid at MUL_LAT+1) is held until UPDATE.
- Step length: S = 2·MUL_LAT+2 cycles.
- The edge that samples Start is E0. Done is high in cycle N·S after E0, for exactly one cycle. Outputs are valid in that same cycle.
- Back-to-back runs: Start is sampled again in IDLE, one cycle after Done.
- Rst low at any time, including mid-step with products in flight:
  - Immediately forces the reset values, aborts the run and flushes the multiplier valid tracking.
  - The first Start after release behaves like a fresh run.
- No overflow detection. Wrap-around is the required behaviour.

## Structure
- Shared package hlsm_pkg:
  - state localparams (8 states, 3-bit);
  - the constant THREE;
  - a function computing ITW.
- Sub-module hlsm_mul_pipe (WIDTH, MUL_LAT):
  - signed WIDTH×WIDTH product truncated to WIDTH;
  - MUL_LAT register stages;
  - async active-low reset on the stage registers.
- All remaining logic (FSM, step counter, working registers, output registers) lives in hlsm_diffeq_iter.

## Test plan
- Single step (MUL_LAT=2): u=1, x=0, y=0, dx=1, a=1 → Done 6 cycles after E0; u1=1, x1=1, y1=1, c=0, iter=1.
- Multi-step: u=2, x=0, y=0, dx=1, a=3 → iter=3, u1=38, x1=3, y1=−6, c=0, Done 18 cycles after E0. Also check intermediate steps (u=2, x=1, y=2) then (u=−10, x=2, y=4).
- Cap (MAX_ITER=4): u=0, x=0, y=0, dx=1, a=100 → iter=4, x1=4, c=1, Done 24 cycles after E0.
- Wrap (WIDTH=8): u=0, y=0, x=127, dx=1, a=−128 → x1=−128 (8'h80), c=0, iter=1.
- Control:
  - Start held high for the whole run → no second run until IDLE.
  - Start pulsed during a step → ignored.
  - Rst asserted in WAIT_C → all outputs 0, Done never pulses.
  - A new Start after Rst release reproduces the single-step result.
- Sweep MUL_LAT ∈ {1, 2, 4} with the multi-step vector → identical results, Done at N·(2·MUL_LAT+2).
